// File: rtl/pipe_arbiter.sv
// pipe_arbiter: round-robin arbiter feeding one fixed-latency, non-stallable
// pipeline. Each issue is tagged with its requester id. Results land in a
// response FIFO that is reserved at issue time: occ counts in-flight plus
// queued entries, so the FIFO never has to refuse a pipeline result.
module pipe_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_W     = 32,
    parameter  int LATENCY    = 3,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      pipe_in_valid,
    output logic [DATA_W-1:0]         pipe_x,
    input  logic [DATA_W-1:0]         pipe_out,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    input  logic                      resp_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } resp_t;

    // operands viewed per requester
    logic [NUM_REQ-1:0][DATA_W-1:0] req_arr;
    assign req_arr = req_data;

    // ---------------- arbitration / credit ----------------
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W-1:0]  cand;
    logic             gnt_found;
    int               c;
    logic [CNT_W-1:0] occ;
    logic             can_issue;
    logic             issue;
    logic             pop;

    // round-robin search starting just after the last issued requester
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        c         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(last_grant) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cand = ID_W'(c);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // a pop in this cycle frees a slot for an issue in the same cycle
    assign pop       = resp_valid & resp_ready;
    assign can_issue = (occ - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH);
    assign issue     = rst & gnt_found & can_issue;

    assign req_ready     = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign pipe_in_valid = issue;
    assign pipe_x        = issue ? req_arr[gnt_idx] : '0;

    // last_grant moves only when something is actually issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_grant <= ID_W'(NUM_REQ - 1);
        else if (issue) last_grant <= gnt_idx;
    end

    // occupancy: issued but not yet popped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // ---------------- in-flight tracking ----------------
    logic [LATENCY-1:0]           vld_pipe;
    logic [LATENCY-1:0][ID_W-1:0] id_pipe;

    // valid/id shift register mirroring the pipeline stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= issue;
            id_pipe[0]  <= gnt_idx;
            for (int s = 1; s < LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    // ---------------- response FIFO ----------------
    logic              push;
    resp_t             push_ent;
    resp_t             head;
    resp_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    // pipe_out is only meaningful in the cycle the tag reaches the last stage
    assign push     = vld_pipe[LATENCY-1];
    assign push_ent = '{id: id_pipe[LATENCY-1], data: pipe_out};

    // storage is write-only on push; no reset needed on the data array
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_ent;
    end

    // pointers and count; push+pop together leaves count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign head       = mem[rd_ptr];
    assign resp_valid = (fifo_cnt != '0);
    assign resp_id    = resp_valid ? head.id   : '0;
    assign resp_data  = resp_valid ? head.data : '0;

    // credit scheme must make these unreachable
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && fifo_cnt == CNT_W'(FIFO_DEPTH)));
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst)
        occ <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter with a behavioural 3-stage pipeline.
// Stimulus pushes expected issues/responses into queues; negedge monitors
// pop and compare whenever the DUT issues or hands over a response.
module tb_pipe_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              pipe_in_valid;
    logic [DW-1:0]     pipe_x;
    logic [DW-1:0]     pipe_out;
    logic              resp_valid;
    logic [1:0]        resp_id;
    logic [DW-1:0]     resp_data;
    logic              resp_ready;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } ent_t;

    ent_t exp_iss[$];
    ent_t exp_rsp[$];
    ent_t ei, er;
    int   n_chk = 0;
    int   n_err = 0;

    pipe_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LATENCY(LAT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pipe_in_valid(pipe_in_valid), .pipe_x(pipe_x), .pipe_out(pipe_out),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pfun(input logic [31:0] x);
        return x * 32'd3 + 32'd7;
    endfunction

    // external pipeline model; never reset, so stale results keep flowing
    logic [31:0]    ps [LAT];
    logic [LAT-1:0] pv = '0;
    always @(posedge clk) begin
        ps[0] <= pfun(pipe_x);
        pv[0] <= pipe_in_valid;
        for (int s = 1; s < LAT; s++) begin
            ps[s] <= ps[s-1];
            pv[s] <= pv[s-1];
        end
    end
    assign pipe_out = pv[LAT-1] ? ps[LAT-1] : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [31:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    // response monitor
    always @(negedge clk) begin
        if (rst && resp_valid && resp_ready) begin
            if (exp_rsp.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL resp_unexpected: got id %0d data %0h expected no response", resp_id, resp_data);
            end else begin
                er = exp_rsp.pop_front();
                chk("resp_id", 64'(resp_id), 64'(er.id));
                chk("resp_data", 64'(resp_data), 64'(er.data));
            end
        end
        if (rst && !resp_valid)
            chk("resp_idle_zero", 64'({resp_id, resp_data}), 64'(0));
    end

    // issue monitor
    always @(negedge clk) begin
        if (rst && pipe_in_valid) begin
            if (exp_iss.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL issue_unexpected: got ready %b x %0h expected no issue", req_ready, pipe_x);
            end else begin
                ei = exp_iss.pop_front();
                chk("issue_onehot", 64'(req_ready), 64'(4'b0001 << ei.id));
                chk("issue_x", 64'(pipe_x), 64'(ei.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    logic [3:0] t4_rv  [10] = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h7, 4'h7, 4'h0};
    logic [3:0] t4_exp [10] = '{4'h4, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0};

    initial begin
        req_valid  = 4'hF;
        req_data   = '0;
        resp_ready = 1'b0;

        // reset state with requests already asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_pipe_in_valid", 64'(pipe_in_valid), 64'(0));
        chk("rst_resp", 64'({resp_valid, resp_id, resp_data}), 64'(0));

        // single request, latency LATENCY+1
        tick();
        rst        = 1'b1;
        req_valid  = 4'b0001;
        set_data(0, 32'd5);
        resp_ready = 1'b1;
        exp_iss.push_back(ent_t'{2'd0, 32'd5});
        exp_rsp.push_back(ent_t'{2'd0, pfun(32'd5)});
        @(negedge clk);
        chk("t1_issue", 64'(pipe_in_valid), 64'(1));
        tick();
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) tick();
            @(negedge clk);
            chk("t1_latency", 64'(resp_valid), 64'(k == 4));
        end
        tick();

        // all four requesting: grants rotate from 1 since last grant was 0
        for (int i = 0; i < NR; i++) set_data(i, 32'h100 + 32'(i));
        for (int k = 0; k < 8; k++) begin
            exp_iss.push_back(ent_t'{2'((k + 1) % 4), 32'h100 + 32'((k + 1) % 4)});
            exp_rsp.push_back(ent_t'{2'((k + 1) % 4), pfun(32'h100 + 32'((k + 1) % 4))});
        end
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_grant", 64'(req_ready), 64'(4'b0001 << ((k + 1) % 4)));
            tick();
        end
        req_valid = '0;
        repeat (6) tick();
        chk("t2_drained", 64'(exp_rsp.size()), 64'(0));

        // backpressure: exactly FIFO_DEPTH issues, then credit-limited
        resp_ready = 1'b0;
        set_data(0, 32'd20);
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            exp_iss.push_back(ent_t'{2'd0, 32'd20 + 32'(k)});
            exp_rsp.push_back(ent_t'{2'd0, pfun(32'd20 + 32'(k))});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t3_fill_ready", 64'(req_ready), 64'(k < 4));
            tick();
            if (k < 4) set_data(0, 32'd21 + 32'(k));
        end
        resp_ready = 1'b1;
        exp_iss.push_back(ent_t'{2'd0, 32'd24});
        exp_rsp.push_back(ent_t'{2'd0, pfun(32'd24)});
        @(negedge clk);
        chk("t3_full_valid", 64'(resp_valid), 64'(1));
        chk("t3_pop_reissue", 64'(req_ready), 64'(1));
        tick();
        resp_ready = 1'b0;
        set_data(0, 32'd25);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t3_full_again", 64'(req_ready), 64'(0));
            tick();
        end
        // result of 24 is pushed in the same cycle as this pop
        resp_ready = 1'b1;
        exp_iss.push_back(ent_t'{2'd0, 32'd25});
        exp_rsp.push_back(ent_t'{2'd0, pfun(32'd25)});
        @(negedge clk);
        chk("t3_push_pop", 64'(req_ready), 64'(1));
        tick();
        resp_ready = 1'b0;
        req_valid  = '0;
        tick();
        resp_ready = 1'b1;
        repeat (8) tick();
        chk("t3_drained", 64'(exp_rsp.size()), 64'(0));

        // grant wrap and last_grant held over idle cycles
        for (int i = 0; i < NR; i++) set_data(i, 32'h300 + 32'(16 * i));
        for (int k = 0; k < 10; k++) begin
            req_valid = t4_rv[k];
            for (int i = 0; i < NR; i++) begin
                if (t4_exp[k][i]) begin
                    exp_iss.push_back(ent_t'{2'(i), 32'h300 + 32'(16 * i)});
                    exp_rsp.push_back(ent_t'{2'(i), pfun(32'h300 + 32'(16 * i))});
                end
            end
            @(negedge clk);
            chk("t4_grant", 64'(req_ready), 64'(t4_exp[k]));
            tick();
        end
        repeat (6) tick();
        chk("t4_drained", 64'(exp_rsp.size()), 64'(0));

        // reset with three operations in flight
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            exp_iss.push_back(ent_t'{2'd0, 32'h400 + 32'(k)});
            set_data(0, 32'h400 + 32'(k));
            @(negedge clk);
            chk("t5_issue", 64'(pipe_in_valid), 64'(1));
            tick();
        end
        req_valid = 4'hF;
        rst       = 1'b0;
        #1;
        chk("t5_async_ready", 64'(req_ready), 64'(0));
        chk("t5_async_issue", 64'({pipe_in_valid, pipe_x}), 64'(0));
        chk("t5_async_resp", 64'({resp_valid, resp_id, resp_data}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t5_no_stale", 64'(resp_valid), 64'(0));
            tick();
        end
        // first grant after reset favours requester 0
        for (int i = 0; i < NR; i++) set_data(i, 32'h500 + 32'(i));
        exp_iss.push_back(ent_t'{2'd0, 32'h500});
        exp_rsp.push_back(ent_t'{2'd0, pfun(32'h500)});
        req_valid = 4'hF;
        @(negedge clk);
        chk("t5_first_grant", 64'(req_ready), 64'(1));
        tick();
        req_valid = '0;
        repeat (6) tick();

        chk("iss_queue_empty", 64'(exp_iss.size()), 64'(0));
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
